fifo_frame_reader: RTL and testbench

- Read-side consumer of the 16-to-32-bit clock-crossing FIFO (non-FWFT, registered output).
- Runs in the FIFO read clock domain: pops 32-bit words, frames them into fixed-length packets with a leading header word, and presents them on a valid/ready stream to the readout/transmit path.
- Absorbs the FIFO read latency with a small skid buffer, so downstream back-pressure never loses or duplicates a word.

---
 rtl/fifo_frame_reader.sv | 183 ++++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_reader
// Description : Read-side consumer of the 16-to-32 bit clock-crossing FIFO.
//               Pops words from a non-FWFT FIFO, frames them into fixed-length
//               packets led by a header word, and presents them on a
//               valid/ready stream. A small skid buffer absorbs the FIFO read
//               latency so back-pressure never loses or duplicates a word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_frame_reader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         FRAME_LEN  = 16,
  parameter int         RD_LATENCY = 1,
  parameter int         SKID_DEPTH = 4,
  parameter logic [7:0] HDR_TAG    = 8'hA5
) (
  input  logic                  RCLOCK,
  input  logic                  RRESET_N,
  input  logic                  ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_Q,
  output logic                  FIFO_RE,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  output logic                  M_LAST,
  input  logic                  M_READY,
  output logic [15:0]           FRAME_CNT,
  output logic                  BUSY
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int c_ptr_w = $clog2(SKID_DEPTH) + 1;
  localparam int c_idx_w = c_ptr_w - 1;
  localparam int c_cnt_w = 9;
  // Credit sum holds occupancy (<= SKID_DEPTH) plus in-flight reads.
  localparam int c_crd_w = c_ptr_w + 2;

  localparam logic [c_cnt_w-1:0] c_frame_len  = c_cnt_w'(FRAME_LEN);
  localparam logic [c_cnt_w-1:0] c_last_idx   = c_cnt_w'(FRAME_LEN - 1);
  localparam logic [c_crd_w-1:0] c_skid_depth = c_crd_w'(SKID_DEPTH);
  localparam logic [7:0]         c_len8       = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [c_cnt_w-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [c_cnt_w-1:0]    out_cnt_q, out_cnt_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];

  logic                  w_fetch_en;
  logic                  w_skid_wr;
  logic                  w_skid_rd;
  logic                  w_skid_empty;
  logic [c_ptr_w-1:0]    w_occ;
  logic [c_crd_w-1:0]    w_inflight;

  assign w_occ        = wr_ptr_q - rd_ptr_q;
  assign w_skid_empty = (wr_ptr_q == rd_ptr_q);
  // The oldest read-pipe flag marks the cycle its FIFO_Q word is valid.
  assign w_skid_wr    = pipe_q[RD_LATENCY-1];
  assign wr_ptr_d     = wr_ptr_q + c_ptr_w'(w_skid_wr);
  assign rd_ptr_d     = rd_ptr_q + c_ptr_w'(w_skid_rd);

  assign FIFO_RE   = w_fetch_en;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = (state_q != ST_IDLE);

  // Count reads already issued but not yet landed in the skid buffer.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + c_crd_w'(pipe_q[i]);
    end
  end

  // Issue a read only when the frame still needs words and a skid slot is reserved.
  always_comb begin
    w_fetch_en = 1'b0;
    if ((state_q != ST_IDLE) && !FIFO_EMPTY && (fetch_cnt_q < c_frame_len) &&
        (({2'b00, w_occ} + w_inflight) < c_skid_depth)) begin
      w_fetch_en = 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_pipe_one
      assign pipe_d = w_fetch_en;
    end else begin : g_pipe_multi
      assign pipe_d = {pipe_q[RD_LATENCY-2:0], w_fetch_en};
    end
  endgenerate

  // Next-state and stream output decode.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    out_cnt_d   = out_cnt_q;
    fetch_cnt_d = fetch_cnt_q + c_cnt_w'(w_fetch_en);
    M_VALID     = 1'b0;
    M_DATA      = '0;
    M_LAST      = 1'b0;
    w_skid_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d     = ST_HDR;
          fetch_cnt_d = '0;
        end
      end
      ST_HDR: begin
        M_VALID = 1'b1;
        M_DATA  = DATA_WIDTH'({HDR_TAG, c_len8, frame_cnt_q});
        if (M_READY) begin
          state_d   = ST_DATA;
          out_cnt_d = '0;
        end
      end
      ST_DATA: begin
        M_VALID = !w_skid_empty;
        M_DATA  = skid_mem_q[rd_ptr_q[c_idx_w-1:0]];
        M_LAST  = !w_skid_empty && (out_cnt_q == c_last_idx);
        if (!w_skid_empty && M_READY) begin
          w_skid_rd = 1'b1;
          out_cnt_d = out_cnt_q + 1'b1;
          if (M_LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            // Prefetch for the next frame only restarts once its header state is entered.
            fetch_cnt_d = '0;
            state_d     = ENABLE ? ST_HDR : ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and frame/word counters.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      fetch_cnt_q <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Read pipe, skid pointers and skid storage; reset discards in-flight reads.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_mem_q[i] <= '0;
      end
    end else begin
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_skid_wr) begin
        skid_mem_q[wr_ptr_q[c_idx_w-1:0]] <= FIFO_Q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_frame_reader
// Description : Self-checking bench for fifo_frame_reader. Two configurations
//               (16 words / latency 1, 1 word / latency 2) run side by side,
//               each with a behavioural FIFO, a stream scoreboard and a
//               monitor that rebuilds the expected frame sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int         FL  = (gi == 0) ? 16 : 1;
      localparam int         RL  = (gi == 0) ? 1 : 2;
      localparam logic [7:0] FL8 = 8'(FL);
      localparam int         KD  = (FL >= 3) ? 4 : 1;  // pos after 3rd data word
      localparam int         KR  = (FL >= 8) ? 8 : 1;  // pos after 7th data word

      logic        rst_n;
      logic        en;
      logic        fifo_empty;
      logic        fifo_re;
      logic [31:0] fifo_q;
      logic [31:0] m_data;
      logic        m_valid;
      logic        m_last;
      logic        m_ready;
      logic [15:0] frame_cnt;
      logic        busy;

      logic [31:0] mem [$];
      logic [31:0] exp_q [$];
      logic [31:0] pq [RL];
      int          re_total = 0;
      int          pos = 0;
      int          frames_total = 0;
      int          frames_rst = 0;
      logic [15:0] seq_m = 16'h0;
      bit          stall = 1'b0;
      bit          cnt_chk = 1'b0;
      logic [31:0] pd;
      logic        pl;
      bit          rmode = 1'b0;
      bit          fin = 1'b0;

      fifo_frame_reader #(
        .FRAME_LEN  (FL),
        .RD_LATENCY (RL)
      ) dut (
        .RCLOCK     (clk),
        .RRESET_N   (rst_n),
        .ENABLE     (en),
        .FIFO_EMPTY (fifo_empty),
        .FIFO_Q     (fifo_q),
        .FIFO_RE    (fifo_re),
        .M_DATA     (m_data),
        .M_VALID    (m_valid),
        .M_LAST     (m_last),
        .M_READY    (m_ready),
        .FRAME_CNT  (frame_cnt),
        .BUSY       (busy)
      );

      assign fifo_q = pq[RL-1];

      // Behavioural non-FWFT FIFO: data appears RL clocks after the read strobe.
      always @(posedge clk or negedge rst_n) begin
        logic [31:0] w;
        if (!rst_n) begin
          mem.delete();
          for (int j = 0; j < RL; j++) pq[j] <= '0;
          fifo_empty <= 1'b1;
          re_total   <= 0;
        end else begin
          for (int j = RL - 1; j > 0; j--) pq[j] <= pq[j-1];
          if (fifo_re) begin
            chk(mem.size() > 0, "fifo_underflow", 64'(mem.size()), 64'd1);
            w = (mem.size() > 0) ? mem.pop_front() : 32'hDEADBEEF;
            pq[0]    <= w;
            re_total <= re_total + 1;
          end
          fifo_empty <= (mem.size() == 0);
        end
      end

      // Monitor: rebuild header/data/last sequence and compare each transfer.
      always @(negedge clk) begin
        logic [31:0] ew;
        logic        el;
        if (!rst_n) begin
          pos        = 0;
          frames_rst = 0;
          stall      = 1'b0;
          cnt_chk    = 1'b0;
          seq_m      = 16'h0;
        end else begin
          chk(!(fifo_re && fifo_empty), "re_while_empty", 64'(fifo_re & fifo_empty), 64'd0);
          if (stall)
            chk(m_valid === 1'b1 && m_data === pd && m_last === pl, "hold_stable",
                {31'd0, m_valid, m_last, m_data}, {31'd0, 1'b1, pl, pd});
          if (cnt_chk) begin
            chk(frame_cnt === seq_m, "frame_cnt", 64'(frame_cnt), 64'(seq_m));
            cnt_chk = 1'b0;
          end
          if (m_valid && m_ready) begin
            if (pos == 0) begin
              ew = {8'hA5, FL8, seq_m};
              el = 1'b0;
            end else begin
              ew = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
              el = (pos == FL);
            end
            chk(m_data === ew && m_last === el, "stream_word",
                {31'd0, m_last, m_data}, {31'd0, el, ew});
            if (pos == FL) begin
              frames_rst++;
              frames_total++;
              chk(re_total == frames_rst * FL, "re_per_frame", 64'(re_total), 64'(frames_rst * FL));
              seq_m   = seq_m + 16'd1;
              cnt_chk = 1'b1;
              pos     = 0;
            end else begin
              pos++;
            end
          end
          stall = m_valid && !m_ready;
          pd    = m_data;
          pl    = m_last;
        end
      end

      task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) m_ready = 1'($urandom_range(0, 1));
      endtask

      task automatic push(input logic [31:0] w);
        mem.push_back(w);
        exp_q.push_back(w);
      endtask

      task automatic wait_frames(input int target, input int budget, input string nm);
        int n = 0;
        while (frames_total < target && n < budget) begin
          tick();
          n++;
        end
        chk(frames_total >= target, nm, 64'(frames_total), 64'(target));
      endtask

      task automatic wait_pos(input int k, input int budget, input string nm);
        int n = 0;
        while (pos < k && n < budget) begin
          tick();
          n++;
        end
        chk(pos >= k, nm, 64'(pos), 64'(k));
      endtask

      task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
          tick();
          n++;
        end
        chk(busy === 1'b0 && m_valid === 1'b0, "idle_after_frame", {62'd0, busy, m_valid}, 64'd0);
      endtask

      initial begin
        int gaps;
        int re0;
        rst_n   = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        chk({fifo_re, m_valid, m_last, busy, m_data, frame_cnt} === '0, "reset_outputs",
            {12'd0, fifo_re, m_valid, m_last, busy, m_data, frame_cnt}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk({fifo_re, m_valid, m_last, busy, frame_cnt} === '0, "idle_after_reset",
            {44'd0, fifo_re, m_valid, m_last, busy, frame_cnt}, 64'd0);

        // Basic frame from preloaded counting data.
        for (int k = 0; k < FL; k++) push(32'(k + 1));
        repeat (2) tick();
        en      = 1'b1;
        m_ready = 1'b1;
        wait_frames(1, 400, "basic_frame_timeout");
        chk(frame_cnt === 16'd1, "basic_frame_cnt", 64'(frame_cnt), 64'd1);

        // Random data under random back-pressure.
        rmode = 1'b1;
        for (int k = 0; k < 2 * FL; k++) push($urandom);
        wait_frames(3, 3000, "backpressure_timeout");
        rmode   = 1'b0;
        m_ready = 1'b1;

        // Starved FIFO: one word every five clocks.
        gaps = 0;
        for (int k = 0; k < FL; k++) begin
          push($urandom);
          for (int t = 0; t < 5; t++) begin
            tick();
            if (busy && !m_valid) gaps++;
          end
        end
        wait_frames(4, 400, "starved_timeout");
        chk(gaps > 0, "starved_gaps", 64'(gaps), 64'd1);

        // ENABLE dropped mid-frame: the frame completes, then nothing more is read.
        for (int k = 0; k < FL; k++) push($urandom);
        wait_pos(KD, 400, "enable_drop_pos_timeout");
        en = 1'b0;
        wait_frames(5, 400, "enable_drop_timeout");
        wait_idle(50);
        for (int k = 0; k < FL; k++) push($urandom);
        re0 = re_total;
        repeat (20) tick();
        chk(re_total == re0, "no_read_when_idle", 64'(re_total), 64'(re0));
        chk(busy === 1'b0, "busy_idle", 64'(busy), 64'd0);

        // Leftover words form the next frame, then reset mid-frame.
        en = 1'b1;
        wait_frames(6, 400, "resume_timeout");
        for (int k = 0; k < FL; k++) push($urandom);
        wait_pos(KR, 400, "reset_pos_timeout");
        rst_n = 1'b0;
        #1;
        chk({fifo_re, m_valid, m_last, busy, m_data, frame_cnt} === '0, "async_reset_outputs",
            {12'd0, fifo_re, m_valid, m_last, busy, m_data, frame_cnt}, 64'd0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk(m_valid === 1'b1 && m_data === {8'hA5, FL8, 16'h0000}, "header_after_reset",
            {31'd0, m_valid, m_data}, {31'd0, 1'b1, 8'hA5, FL8, 16'h0000});
        for (int k = 0; k < FL; k++) push($urandom);
        wait_frames(7, 400, "post_reset_timeout");

        // Bring the FSM to IDLE, then wrap the frame counter.
        for (int k = 0; k < FL; k++) push($urandom);
        wait_pos(1, 400, "wrap_prep_pos_timeout");
        en = 1'b0;
        wait_frames(8, 400, "wrap_prep_timeout");
        wait_idle(50);
        force dut.frame_cnt_q = 16'hFFFF;
        seq_m = 16'hFFFF;
        repeat (2) tick();
        release dut.frame_cnt_q;
        tick();
        chk(frame_cnt === 16'hFFFF, "cnt_preset", 64'(frame_cnt), 64'hFFFF);
        en = 1'b1;
        for (int k = 0; k < FL; k++) push($urandom);
        wait_frames(9, 400, "wrap_timeout");
        chk(frame_cnt === 16'h0000, "cnt_wrap", 64'(frame_cnt), 64'h0);
        en = 1'b0;
        repeat (5) tick();
        chk(exp_q.size() == 0, "all_words_delivered", 64'(exp_q.size()), 64'd0);
        fin = 1'b1;
      end
    end
  endgenerate

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      errors++;
      $display("FAIL global_timeout actual=%0d expected=done", t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
